// File: rtl/updown_pkg.sv
// -----------------------------------------------------------------------------
// updown_pkg
//   Shared types and default widths for the up/down sweep sequencer.
//   - sweep_state_t : controller states
//   - *_DEF         : default parameter values for count, dwell and repeat widths
// -----------------------------------------------------------------------------
package updown_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int DWELL_W_DEF = 4;
  localparam int CYC_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/updown_counter_core.sv
// -----------------------------------------------------------------------------
// updown_counter_core
//   Loadable up/down counter. Load has priority over count enable.
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (count -> 0)
//   en       in   step enable
//   load     in   load load_val (priority over en)
//   load_val in   value to load
//   up_down  in   step direction: 1 = +1, 0 = -1
//   count    out  registered count
// -----------------------------------------------------------------------------
module updown_counter_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= up_down ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
//   Triangle sweep sequencer lo -> hi -> lo with programmable dwell at each
//   bound and programmable number of full sweeps (0 = run until stop).
// Optional feature (macro SWEEP_PAUSE_EN): adds input 'pause' that freezes the
//   sweep while busy; stop still aborts. Without the macro, no pause port.
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start / stop     start request (idle only) / abort request (busy only)
//   lo, hi           sweep bounds, latched on accepted start (lo < hi)
//   dwell            extra hold cycles at each bound, latched on start
//   n_cycles         full sweeps to run, 0 = endless, latched on start
//   pause            (SWEEP_PAUSE_EN only) freeze while busy
//   count            current sweep value
//   up_down          direction of next step (1 = up)
//   busy             sweep in progress
//   at_bound         busy and count sits on a latched bound
//   done / err       one-cycle pulses: sweeps complete / start rejected
// -----------------------------------------------------------------------------
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CYC_W   = CYC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CYC_W-1:0]   n_cycles,
`ifdef SWEEP_PAUSE_EN
  input  logic               pause,
`endif
  output logic [WIDTH-1:0]   count,
  output logic               up_down,
  output logic               busy,
  output logic               at_bound,
  output logic               done,
  output logic               err
);

  sweep_state_t       r_state;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic [DWELL_W-1:0] r_dwell, r_timer;
  logic [CYC_W-1:0]   r_ncyc, r_sweeps;
  logic               r_last;    // final sweep has landed on lo; finish next edge
  logic               r_busy, r_up_down, r_done, r_err;

  logic               w_pause, w_accept, w_run, w_step_en, w_step_up;
  logic               w_last_up, w_last_down, w_hold_end, w_final;
  logic [CYC_W-1:0]   w_sweeps_nxt;

`ifdef SWEEP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_accept     = (r_state == IDLE) && start && (lo < hi);
  assign w_run        = r_busy && !stop && !w_pause;
  assign w_last_up    = (count == r_hi - WIDTH'(1));   // this edge reaches hi
  assign w_last_down  = (count == r_lo + WIDTH'(1));   // this edge reaches lo
  assign w_hold_end   = (r_timer == r_dwell - DWELL_W'(1));
  assign w_sweeps_nxt = r_sweeps + CYC_W'(1);
  assign w_final      = (r_ncyc != '0) && (w_sweeps_nxt == r_ncyc);

  // Count only moves in UP and DOWN; the wrap-up cycle after the final sweep
  // keeps count parked on lo.
  assign w_step_en = w_run && ((r_state == UP) || ((r_state == DOWN) && !r_last));
  assign w_step_up = (r_state == UP);

  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (w_step_en),
    .load     (w_accept),
    .load_val (lo),
    .up_down  (w_step_up),
    .count    (count)
  );

  // NOTE: latched configuration is reset along with control state, so no
  // register ever powers up undefined even though only busy-time values matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lo      <= '0;
      r_hi      <= '0;
      r_dwell   <= '0;
      r_ncyc    <= '0;
      r_timer   <= '0;
      r_sweeps  <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_up_down <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          if (lo < hi) begin
            r_lo      <= lo;
            r_hi      <= hi;
            r_dwell   <= dwell;
            r_ncyc    <= n_cycles;
            r_timer   <= '0;
            r_sweeps  <= '0;
            r_last    <= 1'b0;
            r_busy    <= 1'b1;
            r_up_down <= 1'b1;
            r_state   <= UP;
          end else begin
            r_err <= 1'b1;
          end
        end
      end else if (stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_last  <= 1'b0;
      end else if (!w_pause) begin
        case (r_state)
          UP: begin
            if (w_last_up) begin
              r_timer   <= '0;
              r_up_down <= 1'b0;
              r_state   <= (r_dwell == '0) ? DOWN : HOLD_HI;
            end
          end
          HOLD_HI: begin
            if (w_hold_end) r_state <= DOWN;
            else            r_timer <= r_timer + DWELL_W'(1);
          end
          DOWN: begin
            if (r_last) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_last  <= 1'b0;
            end else if (w_last_down) begin
              r_sweeps <= w_sweeps_nxt;
              r_timer  <= '0;
              if (w_final) begin
                r_last <= 1'b1;
              end else begin
                r_up_down <= 1'b1;
                r_state   <= (r_dwell == '0) ? UP : HOLD_LO;
              end
            end
          end
          HOLD_LO: begin
            if (w_hold_end) r_state <= UP;
            else            r_timer <= r_timer + DWELL_W'(1);
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign up_down  = r_up_down;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign at_bound = r_busy && ((count == r_lo) || (count == r_hi));

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_updown_sweep_ctrl
//   Self-checking bench for updown_sweep_ctrl. A reference model expands each
//   accepted start into the full list of count values the sweep must produce;
//   a compare process checks every output on every falling edge. Directed
//   scenarios add literal expectations. Define SWEEP_PAUSE_EN to add the
//   pause scenario.
// -----------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause;
  logic [7:0] lo, hi, n_cycles;
  logic [3:0] dwell;
  logic [7:0] count;
  logic       up_down, busy, at_bound, done, err;

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.WIDTH(8), .DWELL_W(4), .CYC_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .lo       (lo),
    .hi       (hi),
    .dwell    (dwell),
    .n_cycles (n_cycles),
`ifdef SWEEP_PAUSE_EN
    .pause    (pause),
`endif
    .count    (count),
    .up_down  (up_down),
    .busy     (busy),
    .at_bound (at_bound),
    .done     (done),
    .err      (err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each entry: the count value for one busy cycle and the expected up_down
  // (-1 = not checked).
  typedef struct {
    int v;
    int ud;
  } step_t;

  step_t q[$];
  int    m_count, m_lo, m_hi, m_ud;
  bit    m_busy, m_done, m_err;
  bit    cmp_on = 1'b0;

  function automatic void push(input int v, input int ud);
    step_t s;
    s.v  = v;
    s.ud = ud;
    q.push_back(s);
  endfunction

  // Full waveform of a sweep run; endless runs get two sweeps, more than any
  // scenario uses before stopping.
  function automatic void build(input int l, input int h, input int d, input int n);
    int  sweeps;
    bit  last;
    q.delete();
    push(l, 1);
    sweeps = (n == 0) ? 2 : n;
    for (int s = 0; s < sweeps; s++) begin
      last = (n != 0) && (s == n - 1);
      for (int v = l + 1; v < h; v++) push(v, 1);
      for (int k = 0; k <= d; k++) push(h, 0);
      for (int v = h - 1; v > l; v--) push(v, 0);
      push(l, last ? -1 : 1);
      if (!last) for (int k = 0; k < d; k++) push(l, 1);
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count = 0; m_busy = 0; m_done = 0; m_err = 0;
      m_ud = 1; m_lo = 0; m_hi = 0;
      q.delete();
    end else begin
      m_done = 0;
      m_err  = 0;
      if (m_busy) begin
        if (stop) begin
          m_busy = 0;
          q.delete();
        end else if (!pause) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_busy = 0;
            m_done = 1;
            m_ud   = -1;
          end else begin
            m_count = q[0].v;
            m_ud    = q[0].ud;
          end
        end
      end else if (start) begin
        if (lo < hi) begin
          m_lo = lo;
          m_hi = hi;
          build(lo, hi, dwell, n_cycles);
          m_busy  = 1;
          m_count = q[0].v;
          m_ud    = q[0].ud;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      check("count", count, m_count);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("err", err, m_err);
      check("at_bound", at_bound, m_busy && (m_count == m_lo || m_count == m_hi));
      if (m_ud >= 0) check("up_down", up_down, m_ud);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_start(input int l, input int h, input int d, input int n, input bit s);
    @(negedge clk);
    lo = 8'(l); hi = 8'(h); dwell = 4'(d); n_cycles = 8'(n);
    start = 1'b1; stop = s;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  int seq[16];
  int exp2[16] = '{2, 3, 4, 5, 5, 4, 3, 2, 2, 3, 4, 5, 5, 4, 3, 2};
  int exp5[7]  = '{3, 4, 3, 4, 3, 4, 3};

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    lo = '0; hi = '0; dwell = '0; n_cycles = '0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_up_down", up_down, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_at_bound", at_bound, 0);
    rst = 1'b0;
    cmp_on = 1'b1;

    // 1: asynchronous reset in the middle of a sweep
    do_start(10, 20, 0, 0, 0);
    repeat (5) @(negedge clk);
    check("t1_mid_count", count, 15);
    rst = 1'b1;
    #1;
    check("t1_async_count", count, 0);
    check("t1_async_busy", busy, 0);
    check("t1_async_up_down", up_down, 1);
    check("t1_async_at_bound", at_bound, 0);
    @(negedge clk);
    rst = 1'b0;

    // 2: two sweeps with dwell 1
    do_start(2, 5, 1, 2, 0);
    seq[0] = count;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      seq[i] = count;
    end
    for (int i = 0; i < 16; i++) check("t2_seq", seq[i], exp2[i]);
    @(negedge clk);
    check("t2_done", done, 1);
    check("t2_busy", busy, 0);
    check("t2_count", count, 2);
    @(negedge clk);
    check("t2_done_pulse", done, 0);

    // 3: degenerate bounds are rejected
    do_start(7, 7, 0, 1, 0);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_count", count, 2);
    @(negedge clk);
    check("t3_err_pulse", err, 0);

    // 4: full range, endless, stopped at 100 on the second rise
    do_start(0, 255, 0, 0, 0);
    check("t4_start", count, 0);
    repeat (255) @(negedge clk);
    check("t4_top", count, 255);
    repeat (255) @(negedge clk);
    check("t4_bottom", count, 0);
    repeat (100) @(negedge clk);
    check("t4_at_100", count, 100);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_stop_busy", busy, 0);
    check("t4_stop_count", count, 100);
    check("t4_stop_done", done, 0);

    // 5: narrowest range, start+stop together, start ignored mid-run
    do_start(3, 4, 0, 3, 1);
    seq[0] = count;
    for (int i = 1; i < 7; i++) begin
      if (i == 2) begin lo = 8'd0; hi = 8'd9; start = 1'b1; end
      if (i == 3) start = 1'b0;
      @(negedge clk);
      seq[i] = count;
    end
    for (int i = 0; i < 7; i++) check("t5_seq", seq[i], exp5[i]);
    @(negedge clk);
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_count", count, 3);

`ifdef SWEEP_PAUSE_EN
    // 6: pause freezes the sweep for five cycles
    do_start(0, 9, 0, 0, 0);
    repeat (4) @(negedge clk);
    check("t6_pre", count, 4);
    pause = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t6_frozen", count, 4);
      check("t6_busy", busy, 1);
    end
    pause = 1'b0;
    @(negedge clk);
    check("t6_resume5", count, 5);
    @(negedge clk);
    check("t6_resume6", count, 6);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t6_stop_busy", busy, 0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
